// File: rtl/memwb_stage_reg_if.sv
// MEM/WB stage bus: producer handshake, WB consumer handshake, flush,
// forwarding lookup and the retired-write counter.
interface memwb_stage_reg_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_dest;
  logic              in_we;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_dest;
  logic              out_we;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  wb_count;

  // Pipeline side: presents results, consumes entries, looks up forwards.
  modport master (
    output in_valid, in_data, in_dest, in_we, flush, out_ready, fwd_addr,
    input  in_ready, out_valid, out_data, out_dest, out_we, fwd_hit, fwd_data,
           wb_count
  );

  // The stage register itself.
  modport slave (
    input  in_valid, in_data, in_dest, in_we, flush, out_ready, fwd_addr,
    output in_ready, out_valid, out_data, out_dest, out_we, fwd_hit, fwd_data,
           wb_count
  );
endinterface

// File: rtl/memwb_stage_reg.sv
// MEM/WB pipeline register with a one-entry skid buffer, flush, register
// forwarding lookup and a counter of retired register writes.
module memwb_stage_reg #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic               nclk,
  input  logic               rst_n,
  memwb_stage_reg_if.slave   bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              h_vld, h_vld_d, s_vld, s_vld_d;
  logic              h_we, h_we_d, s_we, s_we_d;
  logic [ADDR_W-1:0] h_dest, h_dest_d, s_dest, s_dest_d;
  logic [DATA_W-1:0] h_data, h_data_d, s_data, s_data_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, retire;
  logic              h_hit, s_hit;

  assign accept = bus.in_valid && ready_q;
  assign retire = h_vld && bus.out_ready;

  // Next-state: entry movement between input, head and skid slots.
  always_comb begin
    state_d  = state_q;
    h_vld_d  = h_vld;
    h_we_d   = h_we;
    h_dest_d = h_dest;
    h_data_d = h_data;
    s_vld_d  = s_vld;
    s_we_d   = s_we;
    s_dest_d = s_dest;
    s_data_d = s_data;
    if (bus.flush) begin
      // Offered result is dropped; a retire this cycle is still counted below.
      state_d = ST_EMPTY;
      h_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d  = ST_ONE;
            h_vld_d  = 1'b1;
            h_we_d   = bus.in_we;
            h_dest_d = bus.in_dest;
            h_data_d = bus.in_data;
          end
        end
        ST_ONE: begin
          if (accept && retire) begin
            h_we_d   = bus.in_we;
            h_dest_d = bus.in_dest;
            h_data_d = bus.in_data;
          end else if (accept) begin
            state_d  = ST_FULL;
            s_vld_d  = 1'b1;
            s_we_d   = bus.in_we;
            s_dest_d = bus.in_dest;
            s_data_d = bus.in_data;
          end else if (retire) begin
            state_d = ST_EMPTY;
            h_vld_d = 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the head can move.
          if (retire) begin
            state_d  = ST_ONE;
            h_we_d   = s_we;
            h_dest_d = s_dest;
            h_data_d = s_data;
            s_vld_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          h_vld_d = 1'b0;
          s_vld_d = 1'b0;
        end
      endcase
    end
    // Registered ready: known one cycle ahead from the next state.
    ready_d = (state_d != ST_FULL);
    cnt_d   = (retire && h_we) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State update; reset overrides flush, accept and retire.
  always_ff @(posedge nclk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      h_vld   <= 1'b0;
      h_we    <= 1'b0;
      h_dest  <= '0;
      h_data  <= '0;
      s_vld   <= 1'b0;
      s_we    <= 1'b0;
      s_dest  <= '0;
      s_data  <= '0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_vld   <= h_vld_d;
      h_we    <= h_we_d;
      h_dest  <= h_dest_d;
      h_data  <= h_data_d;
      s_vld   <= s_vld_d;
      s_we    <= s_we_d;
      s_dest  <= s_dest_d;
      s_data  <= s_data_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  // Head fields are masked so an empty stage presents zeros.
  assign bus.in_ready  = ready_q;
  assign bus.out_valid = h_vld;
  assign bus.out_we    = h_vld & h_we;
  assign bus.out_dest  = h_vld ? h_dest : '0;
  assign bus.out_data  = h_vld ? h_data : '0;
  assign bus.wb_count  = cnt_q;

  // Forwarding: skid is younger than head, so it wins on a double match.
  assign s_hit = s_vld && s_we && (s_dest == bus.fwd_addr);
  assign h_hit = h_vld && h_we && (h_dest == bus.fwd_addr);
  assign bus.fwd_hit  = s_hit || h_hit;
  assign bus.fwd_data = s_hit ? s_data : (h_hit ? h_data : '0);

endmodule
